// File: rtl/sram_controller_pkg.sv
// -----------------------------------------------------------------------------
// sram_controller_pkg
// Shared constants, FSM state type and a small address helper for the
// external 16-bit asynchronous SRAM sequencer.
//   SRAM_ADDR_LEN  : SRAM half-word address width (18)
//   SRAM_DATA_LEN  : SRAM data bus width (16)
//   DATA_MEM_BASE  : CPU byte address that maps to SRAM half-word 0
//   state_t        : sequencer states IDLE / LOW / HIGH / DONE (2 bits)
// -----------------------------------------------------------------------------
package sram_controller_pkg;

    localparam int SRAM_ADDR_LEN = 18;
    localparam int SRAM_DATA_LEN = 16;
    localparam logic [31:0] DATA_MEM_BASE = 32'd1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Half-word address of one half of a 32-bit word: the word index with the
    // half selector appended as the least significant bit.
    function automatic logic [SRAM_ADDR_LEN-1:0] half_addr(
        input logic [SRAM_ADDR_LEN-2:0] word,
        input logic                     half
    );
        return {word, half};
    endfunction

endpackage

// File: rtl/sram_controller_if.sv
// -----------------------------------------------------------------------------
// sram_controller_if
// MEM-stage request bus between the pipeline (master) and the SRAM sequencer
// (slave).
//   wr_en, rd_en : request strobes, driven by the master
//   address      : 32-bit byte address (word aligned)
//   write_data   : 32-bit store data
//   read_data    : 32-bit load result, registered in the slave
//   ready        : access complete, or idle with no request
//
// Handshake: the master raises wr_en or rd_en with address/write_data and
// holds all of them stable until it samples ready == 1 on a rising clock
// edge; that edge completes the transfer and the master may present a new
// request (or drop it) immediately after. ready is also 1 while the slave is
// idle and no request is present.
// -----------------------------------------------------------------------------
interface sram_controller_if;

    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output wr_en, rd_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  wr_en, rd_en, address, write_data,
        output read_data, ready
    );

endinterface

// File: rtl/sram_controller.sv
// -----------------------------------------------------------------------------
// sram_controller
// Splits one 32-bit MEM-stage read/write into two 16-bit asynchronous SRAM
// accesses (low half, then high half), each held for WAIT_STATES+1 cycles.
// ready stays low for the whole access so the pipeline freezes on ~ready.
//
// Parameters:
//   WAIT_STATES  : extra cycles per half-word access, legal range 1..15
//   BASE_ADDRESS : CPU byte address mapped to SRAM half-word 0
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   bus          : pipeline request bus (slave side)
//   SRAM_DQ      : bidirectional SRAM data bus
//   SRAM_ADDR    : SRAM half-word address (registered, holds between accesses)
//   SRAM_WE_N    : write enable, active low
//   SRAM_OE_N    : output enable, active low
//   SRAM_CE_N, SRAM_UB_N, SRAM_LB_N : tied active (0)
//   dbg_state    : current sequencer state
// -----------------------------------------------------------------------------
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int          WAIT_STATES  = 1,
    parameter logic [31:0] BASE_ADDRESS = DATA_MEM_BASE
) (
    input  logic                     clk,
    input  logic                     rst,
    sram_controller_if.slave         bus,
    inout  wire  [SRAM_DATA_LEN-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_LEN-1:0] SRAM_ADDR,
    output logic                     SRAM_WE_N,
    output logic                     SRAM_OE_N,
    output logic                     SRAM_CE_N,
    output logic                     SRAM_UB_N,
    output logic                     SRAM_LB_N,
    output state_t                   dbg_state
);

    localparam int CNT_W = $clog2(WAIT_STATES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_STATES);

    state_t                   state;
    state_t                   state_next;
    logic [CNT_W-1:0]         cnt;
    logic                     op_write;
    logic [31:0]              wdata_q;
    logic                     req;
    logic                     cnt_last;
    logic                     accept;
    logic [31:0]              off;
    logic [SRAM_ADDR_LEN-2:0] word_idx;
    logic                     dq_drive;
    logic [SRAM_DATA_LEN-1:0] dq_out;

    assign req      = bus.wr_en | bus.rd_en;
    assign cnt_last = (cnt == CNT_LAST);
    assign accept   = (state == ST_IDLE) && req;

    // Offset wraps modulo 2^32; the word index keeps offset bits [18:2].
    assign off      = bus.address - BASE_ADDRESS;
    assign word_idx = (SRAM_ADDR_LEN-1)'(off >> 2);

    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_DQ   = dq_drive ? dq_out : 'z;
    assign dbg_state = state;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (req)      state_next = ST_LOW;
            ST_LOW:  if (cnt_last) state_next = ST_HIGH;
            ST_HIGH: if (cnt_last) state_next = ST_DONE;
            ST_DONE:               state_next = ST_IDLE;
            default:               state_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        bus.ready = 1'b0;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        dq_drive  = 1'b0;
        dq_out    = '0;
        case (state)
            ST_IDLE: bus.ready = !req;
            ST_LOW, ST_HIGH: begin
                if (op_write) begin
                    dq_drive = 1'b1;
                    dq_out   = (state == ST_LOW) ? wdata_q[15:0] : wdata_q[31:16];
                    // Pulse ends one cycle early so address/data outlive WE_N.
                    SRAM_WE_N = cnt_last;
                end else begin
                    SRAM_OE_N = 1'b0;
                end
            end
            ST_DONE: bus.ready = 1'b1;
            default: bus.ready = 1'b0;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            op_write      <= 1'b0;
            wdata_q       <= '0;
            SRAM_ADDR     <= '0;
            bus.read_data <= '0;
        end else begin
            // Counter restarts on every phase change, counts inside a phase.
            if (state != state_next) begin
                cnt <= '0;
            end else if (state == ST_LOW || state == ST_HIGH) begin
                cnt <= cnt + CNT_W'(1);
            end

            // Operands are captured once; a simultaneous request is a write.
            if (accept) begin
                op_write  <= bus.wr_en;
                wdata_q   <= bus.write_data;
                SRAM_ADDR <= half_addr(word_idx, 1'b0);
            end

            if (state == ST_LOW && cnt_last) begin
                SRAM_ADDR[0] <= 1'b1;
            end

            if (!op_write && cnt_last) begin
                if (state == ST_LOW) begin
                    bus.read_data[15:0] <= SRAM_DQ;
                end else if (state == ST_HIGH) begin
                    bus.read_data[31:16] <= SRAM_DQ;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// -----------------------------------------------------------------------------
// tb_sram_controller
// Two controller instances (WAIT_STATES 1 and 3) each attached to a
// behavioural 256Kx16 SRAM. Directed accesses from the test plan plus random
// accesses are checked against a word-level reference memory.
// -----------------------------------------------------------------------------
module tb_sram_controller;
    import sram_controller_pkg::*;

    localparam int          W0   = 1;
    localparam int          W1   = 3;
    localparam logic [31:0] BASE = 32'd1024;

    // ---------------------------------------------------- clock and reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    bit   mem_armed = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------ signals
    logic        wr_en_v [2];
    logic        rd_en_v [2];
    logic [31:0] address_v [2];
    logic [31:0] write_data_v [2];
    logic [31:0] read_data_v [2];
    logic        ready_v [2];
    logic [17:0] sa [2];
    logic        we_n [2];
    logic        oe_n [2];
    state_t      st [2];

    wire  [15:0] dq0, dq1;
    logic [17:0] sa0, sa1;
    logic        we_n0, we_n1, oe_n0, oe_n1;
    logic        ce_n0, ce_n1, ub_n0, ub_n1, lb_n0, lb_n1;
    state_t      st0, st1;

    sram_controller_if bus0 ();
    sram_controller_if bus1 ();

    assign bus0.wr_en      = wr_en_v[0];
    assign bus0.rd_en      = rd_en_v[0];
    assign bus0.address    = address_v[0];
    assign bus0.write_data = write_data_v[0];
    assign bus1.wr_en      = wr_en_v[1];
    assign bus1.rd_en      = rd_en_v[1];
    assign bus1.address    = address_v[1];
    assign bus1.write_data = write_data_v[1];

    assign read_data_v[0] = bus0.read_data;
    assign read_data_v[1] = bus1.read_data;
    assign ready_v[0]     = bus0.ready;
    assign ready_v[1]     = bus1.ready;
    assign sa[0]   = sa0;
    assign sa[1]   = sa1;
    assign we_n[0] = we_n0;
    assign we_n[1] = we_n1;
    assign oe_n[0] = oe_n0;
    assign oe_n[1] = oe_n1;
    assign st[0]   = st0;
    assign st[1]   = st1;

    sram_controller #(.WAIT_STATES(W0), .BASE_ADDRESS(BASE)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave),
        .SRAM_DQ(dq0), .SRAM_ADDR(sa0), .SRAM_WE_N(we_n0), .SRAM_OE_N(oe_n0),
        .SRAM_CE_N(ce_n0), .SRAM_UB_N(ub_n0), .SRAM_LB_N(lb_n0),
        .dbg_state(st0)
    );

    sram_controller #(.WAIT_STATES(W1), .BASE_ADDRESS(BASE)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave),
        .SRAM_DQ(dq1), .SRAM_ADDR(sa1), .SRAM_WE_N(we_n1), .SRAM_OE_N(oe_n1),
        .SRAM_CE_N(ce_n1), .SRAM_UB_N(ub_n1), .SRAM_LB_N(lb_n1),
        .dbg_state(st1)
    );

    // ------------------------------------------- behavioural sram models
    logic [15:0] mem0 [0:262143];
    logic [15:0] mem1 [0:262143];

    always @(posedge we_n0) if (mem_armed) mem0[sa0] <= dq0;
    always @(posedge we_n1) if (mem_armed) mem1[sa1] <= dq1;

    assign dq0 = (!oe_n0) ? mem0[sa0] : 16'hzzzz;
    assign dq1 = (!oe_n1) ? mem1[sa1] : 16'hzzzz;

    function automatic logic [15:0] mem_peek(input int u, input logic [17:0] a);
        return (u == 0) ? mem0[a] : mem1[a];
    endfunction

    // ----------------------------------------------------- reference model
    logic [31:0] ref_mem [int];
    logic [31:0] ref_rd [2];
    logic [31:0] exp_q [$];

    function automatic int wait_of(input int u);
        return (u == 0) ? W0 : W1;
    endfunction

    // Word index inside the SRAM: byte offset from BASE, modulo 2^32, in
    // 4-byte words, folded into the 2^17 words the SRAM holds.
    function automatic int word_of(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return int'((off / 4) % 32'd131072);
    endfunction

    // ---------------------------------------------------------- scoreboard
    int n_run  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------ driver tasks
    int last_done_cyc;

    // Presents one request on unit u, follows it to completion and checks
    // freeze length, SRAM addresses, read result and memory contents.
    // Returns just after the DONE edge with the request still applied.
    task automatic access(input int u, input logic wr, input logic rd,
                          input logic [31:0] addr, input logic [31:0] wd);
        int          w, idx, key, freeze;
        bit          done, got_lo, got_hi;
        logic [17:0] a_lo, a_hi;
        logic [31:0] exp_rd;
        w      = wait_of(u);
        idx    = word_of(addr);
        key    = u * 131072 + idx;
        a_lo   = '0;
        a_hi   = '0;
        if (wr) begin
            ref_mem[key] = wd;
            exp_rd = ref_rd[u];
        end else begin
            exp_rd = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
            ref_rd[u] = exp_rd;
        end
        exp_q.push_back(exp_rd);

        wr_en_v[u]      = wr;
        rd_en_v[u]      = rd;
        address_v[u]    = addr;
        write_data_v[u] = wd;

        freeze = 0;
        done   = 1'b0;
        got_lo = 1'b0;
        got_hi = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (st[u] == ST_LOW && !got_lo) begin a_lo = sa[u]; got_lo = 1'b1; end
            if (st[u] == ST_HIGH && !got_hi) begin a_hi = sa[u]; got_hi = 1'b1; end
            if (ready_v[u]) done = 1'b1;
            else freeze++;
        end
        last_done_cyc = cyc;
        check("timeout", 32'(done), 32'd1);
        check("freeze", 32'(freeze), 32'(2 * w + 3));
        check("addr_lo", 32'(a_lo), 32'(2 * idx));
        check("addr_hi", 32'(a_hi), 32'(2 * idx + 1));
        check("read_data", read_data_v[u], exp_q.pop_front());
        if (wr) begin
            check("mem_lo", 32'(mem_peek(u, 18'(2 * idx))), 32'(wd[15:0]));
            check("mem_hi", 32'(mem_peek(u, 18'(2 * idx + 1))), 32'(wd[31:16]));
        end
        @(posedge clk);
        #1;
    endtask

    // Drops the request on unit u and checks it sits ready for n cycles.
    task automatic idle(input int u, input int n);
        wr_en_v[u] = 1'b0;
        rd_en_v[u] = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_ready", 32'(ready_v[u]), 32'd1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_state(input int u);
        check("rst_state", 32'(st[u]), 32'(ST_IDLE));
        check("rst_ready", 32'(ready_v[u]), 32'd1);
        check("rst_read_data", read_data_v[u], 32'h0);
        check("rst_we_n", 32'(we_n[u]), 32'd1);
        check("rst_oe_n", 32'(oe_n[u]), 32'd1);
    endtask

    // ------------------------------------------------------------ watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ stimulus
    initial begin
        int start_cyc;
        bit seen_high;
        for (int u = 0; u < 2; u++) begin
            wr_en_v[u]      = 1'b0;
            rd_en_v[u]      = 1'b0;
            address_v[u]    = '0;
            write_data_v[u] = '0;
            ref_rd[u]       = '0;
        end
        for (int i = 0; i < 262144; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mem_armed = 1'b1;

        // Reset state
        @(negedge clk);
        check_reset_state(0);
        check_reset_state(1);
        check("rst_sram_addr", 32'(sa[0]), 32'h0);
        check("tie_ce_ub_lb", {29'd0, ce_n0, ub_n0, lb_n0}, 32'h0);
        @(posedge clk);
        #1;

        // Write timing: 0xDEADBEEF at 1032 lands in half-words 4 and 5
        access(0, 1'b1, 1'b0, 32'd1032, 32'hDEADBEEF);
        idle(0, 2);
        check("wt_mem4", 32'(mem0[4]), 32'h0000BEEF);
        check("wt_mem5", 32'(mem0[5]), 32'h0000DEAD);

        // Read-back
        access(0, 1'b0, 1'b1, 32'd1032, 32'h0);
        idle(0, 1);
        check("rb_value", read_data_v[0], 32'hDEADBEEF);

        // Simultaneous request acts as a write, read_data untouched
        access(0, 1'b1, 1'b1, 32'd1036, 32'h12345678);
        idle(0, 1);
        check("sim_read_data", read_data_v[0], 32'hDEADBEEF);

        // Back-to-back write then read, requests held
        start_cyc = cyc;
        access(0, 1'b1, 1'b0, 32'd1040, 32'hA5A55A5A);
        access(0, 1'b0, 1'b1, 32'd1040, 32'h0);
        check("b2b_total", 32'(last_done_cyc - start_cyc), 32'd11);
        idle(0, 3);

        // High address on the slower unit
        access(1, 1'b0, 1'b1, BASE + 32'h7FFFC, 32'h0);
        idle(1, 1);
        access(1, 1'b1, 1'b0, BASE + 32'h7FFFC, 32'hCAFEF00D);
        idle(1, 1);
        access(1, 1'b0, 1'b1, 32'd0, 32'h0);
        idle(1, 1);

        // Random accesses on both units
        for (int n = 0; n < 60; n++) begin
            int          u, op;
            logic [31:0] a;
            u  = $urandom_range(0, 1);
            op = $urandom_range(0, 2);
            if ($urandom_range(0, 3) == 0) a = $urandom & 32'hFFFF_FFFC;
            else a = BASE + 32'(4 * $urandom_range(0, 15));
            access(u, (op != 1), (op != 0), a, $urandom);
            idle(u, $urandom_range(0, 2));
        end

        // Reset during HIGH of a read
        idle(0, 1);
        wr_en_v[0]   = 1'b0;
        rd_en_v[0]   = 1'b1;
        address_v[0] = 32'd1032;
        seen_high    = 1'b0;
        for (int c = 0; c < 20 && !seen_high; c++) begin
            @(negedge clk);
            if (st[0] == ST_HIGH) seen_high = 1'b1;
        end
        check("rst_mid_reach_high", 32'(seen_high), 32'd1);
        rst        = 1'b1;
        rd_en_v[0] = 1'b0;
        @(posedge clk);
        #1;
        ref_rd[0] = '0;
        ref_rd[1] = '0;
        @(negedge clk);
        check_reset_state(0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Memory survives the reset
        access(0, 1'b0, 1'b1, 32'd1036, 32'h0);
        idle(0, 2);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Sequencer for the board's external 16-bit asynchronous SRAM, which backs the ARM pipeline's data memory. It takes one 32-bit read or write request from the MEM stage and splits it into two half-word SRAM accesses with programmable wait states. It drives `ready` low for the whole access, so the pipeline stays frozen until the access finishes. The pipeline's freeze signal is `~ready` and feeds the same stage-enable path the hazard logic already gates.

## Interface
- `WAIT_STATES`, default 1: extra cycles held per half-word access; legal range 1..15.
- `BASE_ADDRESS`, default 1024: CPU address that maps to SRAM half-word 0.

Ports:
- `clk` in 1: the single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: MEM-stage write request; held by the pipeline until `ready`.
- `rd_en` in 1: MEM-stage read request; held by the pipeline until `ready`.
- `address` in 32: byte address, word aligned; bits [1:0] are ignored.
- `write_data` in 32: store data.
- `read_data` out 32: load result; registered.
- `ready` out 1: access complete, or idle with no request.
- `SRAM_DQ` inout 16: SRAM data bus.
- `SRAM_ADDR` out 18: SRAM half-word address.
- `SRAM_WE_N` out 1: SRAM write enable, active low.
- `SRAM_OE_N` out 1: SRAM output enable, active low.
- `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N` out 1 each: tied 0.

## Operation
- **Address offset:** `off = address - BASE_ADDRESS`, 32-bit, wraps modulo 2^32.
- **SRAM address:** `SRAM_ADDR = {off[18:2], half}`, where `half` is 0 in LOW and 1 in HIGH.
- **Captured operands:** address, data and op are latched in IDLE when the request is accepted. Inputs are ignored afterwards.
- **FSM states:** IDLE, LOW, HIGH, DONE.
  - IDLE → LOW when `wr_en | rd_en`.
  - LOW → HIGH when `cnt == WAIT_STATES`.
  - HIGH → DONE when `cnt == WAIT_STATES`.
  - DONE → IDLE unconditionally.
- **Wait counter:** `cnt` is `$clog2(WAIT_STATES+1)` bits wide. It clears on entry to LOW and HIGH and increments each cycle in those states.
- **Write phases:**
  - `SRAM_DQ` drives `write_data[15:0]` in LOW and `write_data[31:16]` in HIGH.
  - `SRAM_WE_N = 0` while `cnt < WAIT_STATES`, and 1 on the final cycle of each phase so address and data are held past the end of the write pulse.
  - `SRAM_OE_N = 1`.
- **Read phases:**
  - `SRAM_DQ` is high-Z; `SRAM_OE_N = 0`; `SRAM_WE_N = 1`.
  - On the final cycle of LOW, DQ is registered into `read_data[15:0]`; on the final cycle of HIGH, into `read_data[31:16]`.
- **Simultaneous `wr_en` and `rd_en`:** treated as a write; `read_data` is unchanged.
- **`ready`:** `(state==IDLE && !(wr_en|rd_en)) || state==DONE`.
- **Outside LOW/HIGH:** `SRAM_WE_N = 1`, `SRAM_OE_N = 1`, DQ high-Z, and `SRAM_ADDR` holds its last value.
- **`read_data`:** holds until the next read completes. A write never alters it.

## Timing
- **Reset values:** state IDLE, `cnt` 0, `read_data` 0, `SRAM_WE_N` 1, `SRAM_OE_N` 1, DQ high-Z, `SRAM_ADDR` 0. With no request pending, `ready` is 1.
- **Latency:** cycle 0 is the first cycle the request is seen in IDLE.
  - `ready` is 0 on cycles 0 .. 2W+2 and 1 on cycle 2W+3, with W = `WAIT_STATES`.
  - W = 1 gives 5 freeze cycles.
- **Back-to-back requests:** the pipeline advances on the DONE edge. A new request seen in IDLE on the next cycle starts a new access, so there is exactly one idle cycle between accesses. A held request is never executed twice.
- **Reset mid-access:** `rst` in any state returns to IDLE on that edge, with WE_N/OE_N deasserted and DQ released in the same edge. A partially written word is left as is.
- **Request dropped mid-access:** the access still completes and DONE is still visited. The pipeline contract forbids this case.

## Structure
- Defines.v gains `SRAM_ADDR_LEN` (18), `SRAM_DATA_LEN` (16), `DATA_MEM_BASE` (1024) and the state encodings (2 bits).
- `BASE_ADDRESS` defaults to `DATA_MEM_BASE`.
- Single module, with no RTL sub-module.
- The bench uses a behavioural `sram_model`: 256K×16 array with a write on the WE_N rising edge and combinational read while OE_N is low.

## Test plan
- **Write timing:** W=1, write `0xDEADBEEF` to address 1032.
  - `SRAM_ADDR` 4 then 5.
  - Model holds `0xBEEF` at 4 and `0xDEAD` at 5.
  - `ready` is low for 5 cycles.
- **Read-back:** read 1032 after the write above → `read_data = 0xDEADBEEF` when `ready` rises on cycle 5.
- **Simultaneous request:** `wr_en = rd_en = 1`, `write_data = 0x12345678`, address 1036.
  - Memory is written.
  - `read_data` keeps its prior value.
- **Reset mid-access:** assert `rst` during HIGH of a read.
  - Next cycle: IDLE, `ready = 1` (request low), `read_data = 0`, OE_N = 1.
- **Back-to-back:** write then read, both requests held.
  - Each access completes exactly once.
  - One IDLE cycle separates them.
  - Total 11 cycles.
- **High address / wrap:** W=3, read address 1024+0x7FFFC.
  - `SRAM_ADDR` `0x3FFFE` then `0x3FFFF`.
  - Freeze is 9 cycles.
